// File: rtl/spi_cmd_sequencer.sv
// SPI command sequencer: frames SPI bytes into STATUS/WRITE/READ/START commands.
// Optional macro SPI_CMD_SEQ_AUTO_INC_EN enables address auto-increment for burst access.
module spi_cmd_sequencer #(
  parameter int          ADDR_W     = 6,
  parameter int          RD_TIMEOUT = 16,
  parameter logic [7:0]  ERR_BYTE   = 8'hEE
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic              i_SPI_CS_n,
  input  logic              i_RX_DV,
  input  logic [7:0]        i_RX_Byte,
  output logic              o_TX_DV,
  output logic [7:0]        o_TX_Byte,
  output logic              o_Reg_Wr,
  output logic              o_Reg_Rd,
  output logic [ADDR_W-1:0] o_Reg_Addr,
  output logic [7:0]        o_Reg_WData,
  input  logic [7:0]        i_Reg_RData,
  input  logic              i_Reg_RValid,
  output logic              o_Start,
  input  logic              i_Busy,
  input  logic              i_Done,
  output logic              o_Err
);

  localparam int CNT_W = $clog2(RD_TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_STAT, S_WR_DATA, S_RD_REQ,
    S_RD_WAIT, S_TX_LOAD, S_RD_ARM, S_ERR, S_SINK
  } state_t;

  state_t            state_q, state_d;
  logic              cs_s1_q, cs_s1_d;
  logic              cs_s2_q, cs_s2_d;
  logic              cs_prev_q, cs_prev_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tx_dv_q, tx_dv_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic              reg_wr_q, reg_wr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              start_q, start_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic       cs_fall, cs_rise, done_clr;
  logic [7:0] status;

  always_comb begin
    cs_s1_d   = i_SPI_CS_n;
    cs_s2_d   = cs_s1_q;
    cs_prev_d = cs_s2_q;
    cs_fall   = cs_prev_q & ~cs_s2_q;
    cs_rise   = ~cs_prev_q & cs_s2_q;
    status    = {i_Busy, done_q, err_q, 5'b0};

    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    tx_dv_d   = 1'b0;
    tx_byte_d = tx_byte_q;
    reg_wr_d  = 1'b0;
    wdata_d   = wdata_q;
    start_d   = 1'b0;
    done_d    = done_q;
    err_d     = err_q;
    done_clr  = 1'b0;

`ifdef SPI_CMD_SEQ_AUTO_INC_EN
    // Advance once the write strobe has been presented with the old address.
    if (reg_wr_q) addr_d = addr_q + ADDR_W'(1);
`endif

    if (cs_rise) begin
      state_d = S_IDLE;
    end else if (cs_fall) begin
      state_d   = S_CMD;
      tx_dv_d   = 1'b1;
      tx_byte_d = status;
    end else begin
      case (state_q)
        S_CMD: begin
          if (i_RX_DV) begin
            addr_d = i_RX_Byte[ADDR_W-1:0];
            case (i_RX_Byte[7:6])
              2'b00: begin
                state_d   = S_STAT;
                tx_dv_d   = 1'b1;
                tx_byte_d = status;
                err_d     = 1'b0;
              end
              2'b01: state_d = S_WR_DATA;
              2'b10: state_d = S_RD_REQ;
              default: begin
                state_d = S_SINK;
                if (!i_Busy) begin
                  start_d  = 1'b1;
                  done_clr = 1'b1;
                end else begin
                  err_d     = 1'b1;
                  tx_dv_d   = 1'b1;
                  tx_byte_d = ERR_BYTE;
                end
              end
            endcase
          end
        end
        S_STAT: begin
          if (i_RX_DV) begin
            tx_dv_d   = 1'b1;
            tx_byte_d = status;
          end
        end
        S_WR_DATA: begin
          if (i_RX_DV) begin
            reg_wr_d = 1'b1;
            wdata_d  = i_RX_Byte;
          end
        end
        S_RD_REQ: begin
          cnt_d = '0;
          if (i_RX_DV) err_d = 1'b1;
          if (i_Reg_RValid) begin
            state_d   = S_TX_LOAD;
            tx_dv_d   = 1'b1;
            tx_byte_d = i_Reg_RData;
          end else begin
            state_d = S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (i_RX_DV) err_d = 1'b1;
          if (i_Reg_RValid) begin
            state_d   = S_TX_LOAD;
            tx_dv_d   = 1'b1;
            tx_byte_d = i_Reg_RData;
          end else if (cnt_q == CNT_W'(RD_TIMEOUT - 1)) begin
            state_d   = S_ERR;
            err_d     = 1'b1;
            tx_dv_d   = 1'b1;
            tx_byte_d = ERR_BYTE;
          end
        end
        S_TX_LOAD: begin
`ifdef SPI_CMD_SEQ_AUTO_INC_EN
          addr_d = addr_q + ADDR_W'(1);
`endif
          state_d = i_RX_DV ? S_RD_REQ : S_RD_ARM;
        end
        S_RD_ARM: begin
          // The dummy byte that shifted out the previous read triggers the next.
          if (i_RX_DV) state_d = S_RD_REQ;
        end
        S_ERR: begin
          if (i_RX_DV) begin
            tx_dv_d   = 1'b1;
            tx_byte_d = ERR_BYTE;
          end
        end
        S_IDLE, S_SINK: ;
        default: state_d = S_IDLE;
      endcase
    end

    // A completion arriving with an accepted START leaves the flag set.
    if (i_Done)        done_d = 1'b1;
    else if (done_clr) done_d = 1'b0;
  end

  // CS sync flops reset low so a CS held low across reset never looks like a
  // new frame start; CS must rise and fall again.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q   <= S_IDLE;
      cs_s1_q   <= 1'b0;
      cs_s2_q   <= 1'b0;
      cs_prev_q <= 1'b0;
      addr_q    <= '0;
      cnt_q     <= '0;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= 8'h00;
      reg_wr_q  <= 1'b0;
      wdata_q   <= 8'h00;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cs_s1_q   <= cs_s1_d;
      cs_s2_q   <= cs_s2_d;
      cs_prev_q <= cs_prev_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      tx_dv_q   <= tx_dv_d;
      tx_byte_q <= tx_byte_d;
      reg_wr_q  <= reg_wr_d;
      wdata_q   <= wdata_d;
      start_q   <= start_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign o_TX_DV     = tx_dv_q;
  assign o_TX_Byte   = tx_byte_q;
  assign o_Reg_Wr    = reg_wr_q;
  assign o_Reg_Rd    = (state_q == S_RD_REQ);
  assign o_Reg_Addr  = addr_q;
  assign o_Reg_WData = wdata_q;
  assign o_Start     = start_q;
  assign o_Err       = err_q;

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Bench for spi_cmd_sequencer: directed frame table, corner sequences and
// random frames checked against a transaction-level model of the protocol.
module tb_spi_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cs_n;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       reg_wr, reg_rd;
  logic [5:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;
  logic       reg_rvalid;
  logic       start;
  logic       busy;
  logic       done;
  logic       err;

  always #5 clk = ~clk;

  spi_cmd_sequencer dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_SPI_CS_n(cs_n),
    .i_RX_DV(rx_dv), .i_RX_Byte(rx_byte),
    .o_TX_DV(tx_dv), .o_TX_Byte(tx_byte),
    .o_Reg_Wr(reg_wr), .o_Reg_Rd(reg_rd), .o_Reg_Addr(reg_addr),
    .o_Reg_WData(reg_wdata), .i_Reg_RData(reg_rdata), .i_Reg_RValid(reg_rvalid),
    .o_Start(start), .i_Busy(busy), .i_Done(done), .o_Err(err)
  );

`ifdef SPI_CMD_SEQ_AUTO_INC_EN
  localparam int INC = 1;
`else
  localparam int INC = 0;
`endif

  int nvec  = 0;
  int nfail = 0;

  logic [7:0]  got_tx[$];
  logic [13:0] got_wr[$];
  logic [5:0]  got_rd[$];
  logic        got_st[$];
  logic [7:0]  exp_tx[$];
  logic [13:0] exp_wr[$];
  logic [5:0]  exp_rd[$];
  int          exp_start;

  logic [7:0] rf_mem[64];
  logic [7:0] m_mem[64];
  bit         m_err, m_done;
  bit         resp_en = 1'b1;
  int         rd_lat  = 2;

  typedef struct {
    logic [7:0][7:0] b;
    int              n;
    bit              busy;
    bit              resp;
    bit              done_pre;
    int              exp_ntx;
    logic [7:0]      exp_first;
    logic [7:0]      exp_last;
    int              exp_nwr;
    int              exp_nrd;
    int              exp_nstart;
    bit              exp_err;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pk(input logic [7:0] x0, input logic [7:0] x1,
                                     input logic [7:0] x2);
    return {40'h0, x2, x1, x0};
  endfunction

  // Observed DUT activity and the register file backing store.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_dv) got_tx.push_back(tx_byte);
      if (reg_wr) begin
        got_wr.push_back({reg_addr, reg_wdata});
        rf_mem[reg_addr] <= reg_wdata;
      end
      if (reg_rd) got_rd.push_back(reg_addr);
      if (start) got_st.push_back(1'b1);
    end
  end

  // Register file read responder with configurable latency.
  initial begin
    logic [5:0] a;
    reg_rvalid = 1'b0;
    reg_rdata  = 8'h00;
    forever begin
      @(negedge clk);
      if (reg_rd && resp_en) begin
        a = reg_addr;
        repeat (rd_lat) @(negedge clk);
        reg_rdata  = rf_mem[a];
        reg_rvalid = 1'b1;
        @(negedge clk);
        reg_rvalid = 1'b0;
      end
    end
  end

  task automatic clear_got();
    got_tx.delete();
    got_wr.delete();
    got_rd.delete();
    got_st.delete();
  endtask

  task automatic send_byte(input logic [7:0] v);
    rx_byte = v;
    rx_dv   = 1'b1;
    @(negedge clk);
    rx_dv   = 1'b0;
  endtask

  task automatic pulse_done();
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    m_done = 1'b1;
  endtask

  // Expected frame outcome derived from the command protocol rules.
  task automatic model_frame(input logic [7:0][7:0] b, input int n, input bit bz,
                             input bit rsp);
    logic [5:0] a;
    logic [7:0] st;
    exp_tx.delete();
    exp_wr.delete();
    exp_rd.delete();
    exp_start = 0;
    st = {bz, m_done, m_err, 5'b0};
    exp_tx.push_back(st);
    if (n == 0) return;
    a = b[0][5:0];
    case (b[0][7:6])
      2'b00: begin
        exp_tx.push_back(st);
        m_err = 1'b0;
        for (int i = 1; i < n; i++) exp_tx.push_back({bz, m_done, 1'b0, 5'b0});
      end
      2'b01: begin
        for (int i = 1; i < n; i++) begin
          exp_wr.push_back({a, b[i]});
          m_mem[a] = b[i];
          a = a + 6'(INC);
        end
      end
      2'b10: begin
        if (rsp) begin
          for (int i = 0; i < n; i++) begin
            exp_rd.push_back(a);
            exp_tx.push_back(m_mem[a]);
            a = a + 6'(INC);
          end
        end else begin
          exp_rd.push_back(a);
          m_err = 1'b1;
          for (int i = 0; i < n; i++) exp_tx.push_back(8'hEE);
        end
      end
      default: begin
        if (bz) begin
          m_err = 1'b1;
          exp_tx.push_back(8'hEE);
        end else begin
          exp_start = 1;
          m_done = 1'b0;
        end
      end
    endcase
  endtask

  task automatic compare_frame(input string tag);
    chk({tag, ".ntx"}, got_tx.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size(); i++)
      if (i < got_tx.size()) chk($sformatf("%s.tx%0d", tag, i), got_tx[i], exp_tx[i]);
    chk({tag, ".nwr"}, got_wr.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size(); i++)
      if (i < got_wr.size()) chk($sformatf("%s.wr%0d", tag, i), got_wr[i], exp_wr[i]);
    chk({tag, ".nrd"}, got_rd.size(), exp_rd.size());
    for (int i = 0; i < exp_rd.size(); i++)
      if (i < got_rd.size()) chk($sformatf("%s.rd%0d", tag, i), got_rd[i], exp_rd[i]);
    chk({tag, ".start"}, got_st.size(), exp_start);
    chk({tag, ".err"}, err, m_err);
  endtask

  task automatic run_frame(input logic [7:0][7:0] b, input int n, input bit bz,
                           input bit rsp, input string tag);
    busy    = bz;
    resp_en = rsp;
    clear_got();
    cs_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      send_byte(b[i]);
      repeat (30) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
    model_frame(b, n, bz, rsp);
    compare_frame(tag);
  endtask

  initial begin
    logic [7:0][7:0] rb;
    logic [7:0]      v;
    int              n;

    rst_n = 1'b0; cs_n = 1'b1; rx_dv = 1'b0; rx_byte = 8'h00;
    busy = 1'b0; done = 1'b0;
    m_err = 1'b0; m_done = 1'b0;
    for (int k = 0; k < 64; k++) begin
      v = 8'($urandom);
      rf_mem[k] = v;
      m_mem[k]  = v;
    end
    rf_mem[63] = 8'h3C; m_mem[63] = 8'h3C;
    rf_mem[0]  = 8'h7D; m_mem[0]  = 8'h7D;
    rf_mem[1]  = 8'h5A; m_mem[1]  = 8'h5A;

    repeat (4) @(negedge clk);
    chk("rst.tx_dv", tx_dv, 0);
    chk("rst.tx_byte", tx_byte, 0);
    chk("rst.reg_wr", reg_wr, 0);
    chk("rst.reg_rd", reg_rd, 0);
    chk("rst.addr", reg_addr, 0);
    chk("rst.wdata", reg_wdata, 0);
    chk("rst.start", start, 0);
    chk("rst.err", err, 0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);

    tbl[0]  = '{b:pk(8'h00,8'h00,8'h00), n:0, busy:0, resp:1, done_pre:0, exp_ntx:1,
                exp_first:8'h00, exp_last:8'h00, exp_nwr:0, exp_nrd:0, exp_nstart:0, exp_err:0};
    tbl[1]  = '{b:pk(8'h45,8'hA1,8'hB2), n:3, busy:0, resp:1, done_pre:0, exp_ntx:1,
                exp_first:8'h00, exp_last:8'h00, exp_nwr:2, exp_nrd:0, exp_nstart:0, exp_err:0};
    tbl[2]  = '{b:pk(8'hBF,8'h00,8'h00), n:3, busy:0, resp:1, done_pre:0, exp_ntx:4,
                exp_first:8'h00, exp_last:(INC != 0) ? 8'h5A : 8'h3C, exp_nwr:0, exp_nrd:3,
                exp_nstart:0, exp_err:0};
    tbl[3]  = '{b:pk(8'h80,8'h00,8'h00), n:1, busy:0, resp:0, done_pre:0, exp_ntx:2,
                exp_first:8'h00, exp_last:8'hEE, exp_nwr:0, exp_nrd:1, exp_nstart:0, exp_err:1};
    tbl[4]  = '{b:pk(8'h00,8'h00,8'h00), n:2, busy:0, resp:1, done_pre:0, exp_ntx:3,
                exp_first:8'h20, exp_last:8'h00, exp_nwr:0, exp_nrd:0, exp_nstart:0, exp_err:0};
    tbl[5]  = '{b:pk(8'hC0,8'h00,8'h00), n:1, busy:0, resp:1, done_pre:0, exp_ntx:1,
                exp_first:8'h00, exp_last:8'h00, exp_nwr:0, exp_nrd:0, exp_nstart:1, exp_err:0};
    tbl[6]  = '{b:pk(8'h00,8'h00,8'h00), n:0, busy:0, resp:1, done_pre:1, exp_ntx:1,
                exp_first:8'h40, exp_last:8'h40, exp_nwr:0, exp_nrd:0, exp_nstart:0, exp_err:0};
    tbl[7]  = '{b:pk(8'hC0,8'h55,8'h00), n:2, busy:1, resp:1, done_pre:0, exp_ntx:2,
                exp_first:8'hC0, exp_last:8'hEE, exp_nwr:0, exp_nrd:0, exp_nstart:0, exp_err:1};
    tbl[8]  = '{b:pk(8'h00,8'h00,8'h00), n:1, busy:0, resp:1, done_pre:0, exp_ntx:2,
                exp_first:8'h60, exp_last:8'h60, exp_nwr:0, exp_nrd:0, exp_nstart:0, exp_err:0};
    tbl[9]  = '{b:pk(8'hC0,8'h00,8'h00), n:1, busy:0, resp:1, done_pre:0, exp_ntx:1,
                exp_first:8'h40, exp_last:8'h40, exp_nwr:0, exp_nrd:0, exp_nstart:1, exp_err:0};
    tbl[10] = '{b:pk(8'h7F,8'h11,8'h22), n:3, busy:0, resp:1, done_pre:0, exp_ntx:1,
                exp_first:8'h00, exp_last:8'h00, exp_nwr:2, exp_nrd:0, exp_nstart:0, exp_err:0};

    for (int t = 0; t < 11; t++) begin
      if (tbl[t].done_pre) pulse_done();
      run_frame(tbl[t].b, tbl[t].n, tbl[t].busy, tbl[t].resp, $sformatf("tbl%0d", t));
      chk($sformatf("tbl%0d.ntx_hand", t), got_tx.size(), tbl[t].exp_ntx);
      if (got_tx.size() > 0) begin
        chk($sformatf("tbl%0d.first", t), got_tx[0], tbl[t].exp_first);
        chk($sformatf("tbl%0d.last", t), got_tx[got_tx.size()-1], tbl[t].exp_last);
      end
      chk($sformatf("tbl%0d.nwr_hand", t), got_wr.size(), tbl[t].exp_nwr);
      chk($sformatf("tbl%0d.nrd_hand", t), got_rd.size(), tbl[t].exp_nrd);
      chk($sformatf("tbl%0d.start_hand", t), got_st.size(), tbl[t].exp_nstart);
      chk($sformatf("tbl%0d.err_hand", t), err, tbl[t].exp_err);
    end

    // CS rises while a read is outstanding; the late response must be dropped.
    busy = 1'b0; resp_en = 1'b1; rd_lat = 10;
    clear_got();
    cs_n = 1'b0;
    repeat (8) @(negedge clk);
    send_byte(8'h82);
    repeat (3) @(negedge clk);
    cs_n = 1'b1;
    repeat (25) @(negedge clk);
    chk("abort.ntx", got_tx.size(), 1);
    if (got_tx.size() > 0) chk("abort.status", got_tx[0], {1'b0, m_done, m_err, 5'b0});
    chk("abort.nrd", got_rd.size(), 1);
    chk("abort.err", err, m_err);
    rd_lat = 2;
    run_frame(pk(8'h47, 8'h99, 8'h00), 2, 1'b0, 1'b1, "after_abort");

    // A byte arriving while the read is still pending flags an error but the
    // read itself still completes.
    rd_lat = 8;
    clear_got();
    cs_n = 1'b0;
    repeat (8) @(negedge clk);
    send_byte(8'h81);
    repeat (3) @(negedge clk);
    send_byte(8'h33);
    repeat (30) @(negedge clk);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("fast.ntx", got_tx.size(), 2);
    if (got_tx.size() > 1) chk("fast.data", got_tx[1], m_mem[1]);
    chk("fast.nrd", got_rd.size(), 1);
    chk("fast.err", err, 1);
    m_err = 1'b1;
    rd_lat = 2;

    // Reset in the middle of a write frame, with CS held low throughout.
    cs_n = 1'b0;
    repeat (8) @(negedge clk);
    send_byte(8'h45);
    repeat (5) @(negedge clk);
    clear_got();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst.err", err, 0);
    chk("midrst.tx_byte", tx_byte, 0);
    chk("midrst.addr", reg_addr, 0);
    send_byte(8'h11);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    send_byte(8'h22);
    repeat (10) @(negedge clk);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("midrst.ntx", got_tx.size(), 0);
    chk("midrst.nwr", got_wr.size(), 0);
    chk("midrst.nrd", got_rd.size(), 0);
    chk("midrst.start", got_st.size(), 0);
    m_err = 1'b0;
    m_done = 1'b0;

    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 4) == 0) pulse_done();
      rd_lat = $urandom_range(1, 4);
      n = $urandom_range(0, 4);
      rb = '0;
      for (int i = 0; i < 8; i++) rb[i] = 8'($urandom);
      run_frame(rb, n, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0),
                $sformatf("rnd%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
